// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state type and SQI constants for the logic-analyzer SRAM reader
package la_pkg;

    localparam int LA_WIDTH = 8;

    localparam logic [7:0] SQI_CMD_READ = 8'h03;

    localparam int CMD_NIBBLES   = 2;
    localparam int ADDR_NIBBLES  = 6;
    localparam int DUMMY_NIBBLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_FINISH
    } rd_state_t;

endpackage

// File: rtl/sqi_nibble_shifter.sv
// rtl/sqi_nibble_shifter.sv - command+address nibble shifter, MSB nibble first, replicated on every chip lane
module sqi_nibble_shifter #(
    parameter int LANES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [31:0]          load_data,
    input  logic                 shift,
    output logic [4*LANES-1:0]   sio_tdo
);

    logic [31:0] sreg;

    // Load the full header at burst start, then advance one nibble per SCK; zeros fill in behind
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= {sreg[27:0], 4'h0};
        end
    end

    assign sio_tdo = {LANES{sreg[31:28]}};

endmodule

// File: rtl/la_sram_reader.sv
// rtl/la_sram_reader.sv - SQI read engine streaming samples from the LA SRAM pair; option LA_SRAM_READER_DUMMY_EN
module la_sram_reader #(
    parameter int LA_WIDTH = la_pkg::LA_WIDTH,
    parameter int LA_CHIPS = 2,
    parameter int LEN_W    = 17
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [23:0]         start_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [LA_WIDTH-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [LA_CHIPS-1:0] sram_clock,
    output logic [LA_CHIPS-1:0] sram_cs,
    output logic                sram_sio_oe,
    output logic [LA_WIDTH-1:0] sram_sio_tdo,
    input  logic [LA_WIDTH-1:0] sram_sio_tdi
);

    import la_pkg::*;

`ifdef LA_SRAM_READER_DUMMY_EN
    localparam rd_state_t POST_ADDR = ST_DUMMY;
`else
    localparam rd_state_t POST_ADDR = ST_DATA;
`endif

    rd_state_t          state_q, state_d;
    logic               ph_q, ph_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               sck_q, sck_d;
    logic               cs_q, cs_d;
    logic               oe_q, oe_d;
    logic               busy_d, done_d, valid_d;
    logic [LA_WIDTH-1:0] data_d;
    logic               sh_load, sh_shift;
    logic [2:0]         last_cnt;
    rd_state_t          after_hdr;

    sqi_nibble_shifter #(
        .LANES (LA_WIDTH / 4)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (sh_load),
        .load_data ({SQI_CMD_READ, start_addr}),
        .shift     (sh_shift),
        .sio_tdo   (sram_sio_tdo)
    );

    // SCK count and successor for whichever header-type state is active
    always_comb begin
        last_cnt  = 3'(CMD_NIBBLES - 1);
        after_hdr = ST_ADDR;
        case (state_q)
            ST_ADDR: begin
                last_cnt  = 3'(ADDR_NIBBLES - 1);
                after_hdr = POST_ADDR;
            end
            ST_DUMMY: begin
                last_cnt  = 3'(DUMMY_NIBBLES - 1);
                after_hdr = ST_DATA;
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        sck_d       = sck_q;
        cs_d        = cs_q;
        busy_d      = busy;
        done_d      = 1'b0;
        data_d      = sample_data;
        valid_d     = sample_valid;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;

        // A handshake retires the held sample; a capture below overrides this
        if (sample_valid && sample_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = ST_CMD;
                        ph_d        = 1'b0;
                        cnt_d       = '0;
                        remaining_d = length;
                        busy_d      = 1'b1;
                        cs_d        = 1'b0;
                        sh_load     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY: begin
                if (!ph_q) begin
                    ph_d  = 1'b1;
                    sck_d = 1'b1;
                end else begin
                    ph_d     = 1'b0;
                    sck_d    = 1'b0;
                    cnt_d    = cnt_q + 3'd1;
                    sh_shift = (state_q != ST_DUMMY);
                    if (cnt_q == last_cnt) begin
                        cnt_d   = '0;
                        state_d = after_hdr;
                    end
                end
            end

            ST_DATA: begin
                if (!ph_q) begin
                    // Hold SCK low while an unaccepted sample is pending so nothing is overwritten
                    if (!sample_valid || sample_ready) begin
                        if (remaining_q == '0) begin
                            state_d = ST_FINISH;
                            cs_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            ph_d  = 1'b1;
                            sck_d = 1'b1;
                        end
                    end
                end else begin
                    ph_d        = 1'b0;
                    sck_d       = 1'b0;
                    data_d      = sram_sio_tdi;
                    valid_d     = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The engine drives SIO only while it is sending the command and address
        oe_d = (state_d == ST_CMD) || (state_d == ST_ADDR);
    end

    // State and registered outputs; reset aborts any transfer by raising CS with no done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ph_q         <= 1'b0;
            cnt_q        <= '0;
            remaining_q  <= '0;
            sck_q        <= 1'b0;
            cs_q         <= 1'b1;
            oe_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            sck_q        <= sck_d;
            cs_q         <= cs_d;
            oe_q         <= oe_d;
            busy         <= busy_d;
            done         <= done_d;
            sample_data  <= data_d;
            sample_valid <= valid_d;
        end
    end

    assign sram_clock  = {LA_CHIPS{sck_q}};
    assign sram_cs     = {LA_CHIPS{cs_q}};
    assign sram_sio_oe = oe_q;

endmodule

// File: tb/tb_la_sram_reader.sv
// tb/tb_la_sram_reader.sv - self-checking bench for la_sram_reader with a behavioural SQI SRAM pair
module tb_la_sram_reader;

    localparam int LEN_W   = 17;
    localparam int HDR_SCK = 8;
`ifdef LA_SRAM_READER_DUMMY_EN
    localparam int DUMMY_SCK = 2;
`else
    localparam int DUMMY_SCK = 0;
`endif
    // Cycle index 1 is the cycle after the start-accepting edge; data lands on the edge closing ph=1
    localparam int EXP_FIRST_VALID = 2 * (HDR_SCK + DUMMY_SCK + 1) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [23:0]       start_addr;
    logic [LEN_W-1:0]  length;
    logic              busy, done;
    logic [7:0]        sample_data;
    logic              sample_valid, sample_ready;
    logic [1:0]        sram_clock, sram_cs;
    logic              sram_sio_oe;
    logic [7:0]        sram_sio_tdo;
    logic [7:0]        sram_sio_tdi;

    int n_cmp  = 0;
    int n_fail = 0;

    la_sram_reader #(.LA_WIDTH(8), .LA_CHIPS(2), .LEN_W(LEN_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sram_clock   (sram_clock),
        .sram_cs      (sram_cs),
        .sram_sio_oe  (sram_sio_oe),
        .sram_sio_tdo (sram_sio_tdo),
        .sram_sio_tdi (sram_sio_tdi)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM pair: header nibbles in, sequential bytes out after the dummy clocks
    logic [7:0]  mem [256];
    logic [31:0] hdr;
    int rises, sck_rise_total, cs_fall_total, lane_err, oe_err;

    always @(negedge sram_cs[0]) begin
        rises = 0;
        cs_fall_total++;
    end

    always @(posedge sram_clock[0]) begin
        sck_rise_total++;
        if (sram_cs[0] === 1'b0) begin
            rises++;
            if (rises <= HDR_SCK) begin
                hdr = {hdr[27:0], sram_sio_tdo[3:0]};
                if (sram_sio_tdo[7:4] !== sram_sio_tdo[3:0]) lane_err++;
                if (sram_sio_oe !== 1'b1) oe_err++;
            end else begin
                if (sram_sio_oe !== 1'b0) oe_err++;
                if (rises > HDR_SCK + DUMMY_SCK)
                    sram_sio_tdi = mem[8'(hdr[7:0] + 8'(rises - HDR_SCK - DUMMY_SCK - 1))];
            end
        end
    end

    // Burst observations filled by run_burst
    logic [7:0] got [$];
    int  hs_cyc [$];
    int  first_valid_cyc, done_cyc, cs_first, sck_first, stall_sck_hi, busy_lo;
    logic [1:0] done_cs;
    logic done_busy;
    bit  timed_out;

    function automatic logic [7:0] exp_sample(input logic [23:0] a, input int i);
        return mem[8'(a[7:0] + 8'(i))];
    endfunction

    task automatic run_burst(input logic [23:0] a, input int len, input int stall_len,
                             input bit rand_ready, input bit restart);
        int cyc, stall_left;
        bit seen_valid;
        got.delete(); hs_cyc.delete();
        first_valid_cyc = -1; done_cyc = -1; cs_first = -1; sck_first = -1;
        stall_sck_hi = 0; busy_lo = 0; timed_out = 0; lane_err = 0; oe_err = 0;
        seen_valid = 0; stall_left = stall_len; cyc = 0;
        @(negedge clock);
        start = 1'b1; start_addr = a; length = LEN_W'(len); sample_ready = 1'b1;
        while (done_cyc < 0 && !timed_out) begin
            @(negedge clock);
            cyc++;
            start = restart && (cyc == 6);
            if (restart && cyc == 6) begin
                start_addr = a ^ 24'h0000f0;
                length     = LEN_W'(len + 5);
            end
            if (cs_first < 0 && sram_cs == 2'b00) cs_first = cyc;
            if (sck_first < 0 && sram_clock == 2'b11) sck_first = cyc;
            if (sample_valid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (seen_valid && stall_left > 0) begin
                sample_ready = 1'b0;
                stall_left--;
                if (sram_clock != 2'b00) stall_sck_hi++;
            end else begin
                sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done) begin
                done_cyc  = cyc;
                done_cs   = sram_cs;
                done_busy = busy;
            end else if (!busy) begin
                busy_lo++;
            end
            if (sample_valid && sample_ready) begin
                got.push_back(sample_data);
                hs_cyc.push_back(cyc);
            end
            if (cyc > 3000) timed_out = 1;
        end
        start = 1'b0;
        sample_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; sample_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (sram_cs !== 2'b11) begin n_fail++; $display("FAIL reset_cs got=%b exp=11", sram_cs); end
        n_cmp++; if (sram_clock !== 2'b00) begin n_fail++; $display("FAIL reset_sck got=%b exp=00", sram_clock); end
        n_cmp++; if (sram_sio_oe !== 1'b0 || sram_sio_tdo !== 8'h00) begin n_fail++; $display("FAIL reset_sio got oe=%b tdo=%h exp oe=0 tdo=00", sram_sio_oe, sram_sio_tdo); end
        n_cmp++; if ({busy, done, sample_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, done, sample_valid}); end
        n_cmp++; if (sample_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", sample_data); end
    endtask

    task automatic check_stream(input string name, input logic [23:0] a, input int len);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout got=no done exp=done", name); end
        n_cmp++; if (got.size() != len) begin n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, got.size(), len); end
        for (int i = 0; i < got.size() && i < len; i++) begin
            n_cmp++;
            if (got[i] !== exp_sample(a, i)) begin n_fail++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, got[i], exp_sample(a, i)); end
        end
        n_cmp++; if (hdr !== {8'h03, a}) begin n_fail++; $display("FAIL %s_header got=%h exp=%h", name, hdr, {8'h03, a}); end
        n_cmp++; if (lane_err != 0 || oe_err != 0) begin n_fail++; $display("FAIL %s_sio got lane_err=%0d oe_err=%0d exp=0/0", name, lane_err, oe_err); end
        n_cmp++; if (rises != HDR_SCK + DUMMY_SCK + len) begin n_fail++; $display("FAIL %s_sck_count got=%0d exp=%0d", name, rises, HDR_SCK + DUMMY_SCK + len); end
        n_cmp++; if (hs_cyc.size() > 0 && done_cyc != hs_cyc[hs_cyc.size()-1] + 1) begin n_fail++; $display("FAIL %s_done_time got=%0d exp=%0d", name, done_cyc, hs_cyc[hs_cyc.size()-1] + 1); end
        n_cmp++; if (done_cs !== 2'b11 || done_busy !== 1'b0 || busy_lo != 0) begin n_fail++; $display("FAIL %s_done_state got cs=%b busy=%b busy_lo=%0d exp cs=11 busy=0 busy_lo=0", name, done_cs, done_busy, busy_lo); end
    endtask

    task automatic test_basic();
        mem[8'h45] = 8'hA5; mem[8'h46] = 8'h5A; mem[8'h47] = 8'hFF; mem[8'h48] = 8'h00;
        run_burst(24'h012345, 4, 0, 0, 0);
        check_stream("basic", 24'h012345, 4);
        n_cmp++; if (cs_first != 1 || sck_first != 2) begin n_fail++; $display("FAIL basic_latency got cs=%0d sck=%0d exp cs=1 sck=2", cs_first, sck_first); end
        n_cmp++; if (first_valid_cyc != EXP_FIRST_VALID) begin n_fail++; $display("FAIL basic_first_valid got=%0d exp=%0d", first_valid_cyc, EXP_FIRST_VALID); end
        for (int i = 1; i < hs_cyc.size(); i++) begin
            n_cmp++; if (hs_cyc[i] - hs_cyc[i-1] != 2) begin n_fail++; $display("FAIL basic_rate[%0d] got=%0d exp=2", i, hs_cyc[i] - hs_cyc[i-1]); end
        end
        @(negedge clock);
        n_cmp++; if (done !== 1'b0 || sram_cs !== 2'b11) begin n_fail++; $display("FAIL basic_done_pulse got done=%b cs=%b exp done=0 cs=11", done, sram_cs); end
    endtask

    task automatic test_stall();
        run_burst(24'h012345, 4, 10, 0, 0);
        check_stream("stall", 24'h012345, 4);
        n_cmp++; if (stall_sck_hi != 0) begin n_fail++; $display("FAIL stall_sck got=%0d exp=0", stall_sck_hi); end
    endtask

    task automatic test_len_zero();
        int cs0, sck0, pulses;
        cs0 = cs_fall_total; sck0 = sck_rise_total; pulses = 0;
        @(negedge clock);
        start = 1'b1; start_addr = 24'h00abcd; length = '0;
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_done got done=%b busy=%b exp done=1 busy=0", done, busy); end
        repeat (6) begin
            @(negedge clock);
            if (done) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL len0_pulse_width got=%0d exp=0", pulses); end
        n_cmp++; if (cs_fall_total != cs0 || sck_rise_total != sck0) begin n_fail++; $display("FAIL len0_bus got cs_falls=%0d sck_rises=%0d exp=0/0", cs_fall_total - cs0, sck_rise_total - sck0); end
    endtask

    task automatic test_reset_mid_burst();
        int waited, dones;
        logic [23:0] a;
        waited = 0; dones = 0;
        @(negedge clock);
        start = 1'b1; start_addr = 24'h000010; length = LEN_W'(6);
        @(negedge clock);
        start = 1'b0;
        while (rises < 4 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        n_cmp++; if (rises < 4) begin n_fail++; $display("FAIL midreset_reach_addr got rises=%0d exp>=4", rises); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++; if (sram_cs !== 2'b11 || sram_sio_oe !== 1'b0 || sram_clock !== 2'b00) begin n_fail++; $display("FAIL midreset_bus got cs=%b oe=%b sck=%b exp 11/0/00", sram_cs, sram_sio_oe, sram_clock); end
        n_cmp++; if ({busy, done, sample_valid} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags got=%b exp=000", {busy, done, sample_valid}); end
        repeat (30) begin
            @(negedge clock);
            if (done) dones++;
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
        a = 24'($urandom);
        run_burst(a, 5, 0, 0, 0);
        check_stream("after_reset", a, 5);
    endtask

    task automatic test_restart_ignored();
        logic [23:0] a;
        a = 24'($urandom);
        run_burst(a, 3, 0, 0, 1);
        check_stream("restart", a, 3);
    endtask

    task automatic test_random();
        logic [23:0] a;
        int len;
        for (int b = 0; b < 6; b++) begin
            a   = 24'($urandom);
            len = $urandom_range(1, 12);
            run_burst(a, len, (b % 2) * $urandom_range(1, 7), 1, 0);
            check_stream($sformatf("rand%0d", b), a, len);
        end
    endtask

    initial begin
        sram_sio_tdi = 8'h00;
        hdr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_reset_mid_burst();
        test_restart_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/la_sram_reader.md
# la_sram_reader

Quad-SPI (SQI) read engine for the two logic-analyzer SRAMs. It acts as the initiator that pulls captured samples back out of the SRAM pair and streams them to the FPGA fabric over a valid/ready interface. The SRAMs are wired in nibble-parallel: chip 0 holds sample bits [3:0] on sio[3:0], and chip 1 holds bits [7:4] on sio[7:4]. Each SRAM clock therefore yields one 8-bit sample. The block sits between the `sram_sio` SB_IO tristate cells and the sample FIFO / memory-controller register file.

## Interface
Parameters:
- `LA_WIDTH`, 8, sample width; fixed to 2 chips × 4 bits.
- `LA_CHIPS`, 2, number of SRAMs; all chip selects are driven together.
- `LEN_W`, 17, width of the burst-length count (128 KiB per chip).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `start_addr`  in  24  SRAM byte address of the first sample.
- `length`  in  LEN_W  number of samples to read.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the burst is complete.
- `sample_data`  out  LA_WIDTH  sample value, {chip1 nibble, chip0 nibble}.
- `sample_valid`  out  1  `sample_data` is valid.
- `sample_ready`  in  1  consumer accepts the sample when valid && ready.
- `sram_clock`  out  LA_CHIPS  SRAM SCK, identical on all bits, idles low.
- `sram_cs`  out  LA_CHIPS  chip selects, active low, identical on all bits, idle high.
- `sram_sio_oe`  out  1  tristate output enable for all 8 SIO pins.
- `sram_sio_tdo`  out  LA_WIDTH  SIO drive value; the same nibble is driven on [3:0] and [7:4].
- `sram_sio_tdi`  in  LA_WIDTH  SIO pin input from SB_IO.

## Operation
- SCK runs at half rate, using phase bit `ph`:
  - ph=0: `sram_clock`=0, and outgoing nibbles update.
  - ph=1: `sram_clock`=1, and incoming nibbles are captured at the end of the ph=1 cycle.
- Transfer states:
  - IDLE: accepts `start`.
  - CMD: 2 SCK, nibbles 0x0 then 0x3 (READ 0x03).
  - ADDR: 6 SCK, `start_addr` MSB nibble first.
  - DUMMY: 2 SCK.
  - DATA: `length` SCK.
  - FINISH: one cycle, then back to IDLE.
- On `start` in IDLE with `length`≠0:
  - latch `start_addr` and `length`, set `busy`, assert `sram_cs`=0, enter CMD at ph=0.
- On `start` in IDLE with `length`=0:
  - pulse `done` next cycle; `busy` stays 0; CS stays high; no SCK.
- `start` while `busy` is ignored.
- `sram_sio_oe`=1 during CMD and ADDR, and 0 from the first DUMMY ph=0 onward (bus turnaround).
- DATA capture:
  - each SCK rising phase loads `sram_sio_tdi` into `sample_data` and sets `sample_valid`.
  - each capture decrements the remaining count.
- Backpressure:
  - if `sample_valid` && !`sample_ready` at a ph=0 cycle in DATA, the engine holds ph=0 (SCK low, CS low) until the sample is accepted.
  - a stalled SCK is legal for the SRAM.
  - no sample is ever overwritten.
- After the last capture, the engine waits for that sample's handshake, then enters FINISH.
- FINISH: `sram_cs`=1, `done`=1, `busy`=0 on the following cycle.
- Address wrap inside the SRAM is the SRAM's own sequential-mode behaviour; this block does not bound `start_addr`+`length`.

## Timing
- Reset values:
  - `sram_cs`=all 1, `sram_clock`=0, `sram_sio_oe`=0, `sram_sio_tdo`=0.
  - `busy`=0, `done`=0, `sample_valid`=0, `sample_data`=0.
  - state IDLE, ph=0.
- Reset mid-burst: all outputs take reset values on the next edge; no `done` pulse; the SRAM sees CS rise (transfer aborted).
- All outputs are registered.
- Latency with no stall:
  - `start` → CS low: 1 cycle.
  - first SCK rise: 2 cycles after `start`.
  - first `sample_valid`: after (2+6+2+1)×2 cycles = 22 cycles.
- Throughput: one sample per 2 clocks when `sample_ready` is held high.
- Simultaneous handshake and new capture in the same cycle: the new capture wins and `sample_valid` stays 1.

## Configuration
- `LA_SRAM_READER_DUMMY_EN`:
  - defined: the DUMMY state inserts 2 SCK (23LC1024 SQI read timing); first sample at 22 cycles.
  - undefined: DUMMY is skipped; ADDR goes straight to DATA with turnaround at the first DATA ph=0; first sample at 18 cycles.

## Structure
- Shared package `la_pkg`:
  - state enum.
  - `SQI_CMD_READ`=8'h03.
  - nibble counts: CMD=2, ADDR=6, DUMMY=2.
  - `LA_WIDTH`.
- Sub-module `sqi_nibble_shifter`: 32-bit command+address load, MSB-nibble-first shift on ph=0, replicated onto both chips' nibble lanes. Everything else stays in one module.

## Test plan
- Reset, then `start` with addr 0x012345, len 4, ready=1:
  - SIO drives 0,3,0,1,2,3,4,5.
  - oe drops at DUMMY.
  - SRAM model returns 0xA5,0x5A,0xFF,0x00.
  - stream carries exactly those 4 samples.
  - `done` asserts 1 cycle after the 4th handshake; CS high.
- Same burst with ready low for 10 cycles after the first valid:
  - SCK held low and no extra captures during the stall.
  - all 4 samples arrive in order and none are lost.
- `start` with len 0: `done` pulses next cycle; CS never falls; SCK never toggles.
- `reset` asserted during ADDR: next cycle CS=all 1, oe=0, valid=0, busy=0, no `done`; a new `start` then runs a clean burst.
- `start` pulsed again while busy: ignored; burst length unchanged.
- Build with and without `LA_SRAM_READER_DUMMY_EN`: first `sample_valid` at cycle 22 vs 18 after `start`.
